// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one request at a time over a req/gnt/rvalid data port.
// Misaligned accesses become two word-aligned transactions whose read data is merged and extended.
module lsu_ctrl #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  lsu_req_i,
    output logic                  lsu_ready_o,
    input  logic                  lsu_we_i,
    input  logic [1:0]            lsu_type_i,
    input  logic [1:0]            lsu_ext_i,
    input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
    input  logic [31:0]           lsu_wdata_i,
    output logic                  lsu_rvalid_o,
    output logic [31:0]           lsu_rdata_o,
    output logic                  lsu_busy_o,
    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    output logic [ADDR_WIDTH-1:0] data_addr_o,
    output logic                  data_we_o,
    output logic [3:0]            data_be_o,
    output logic [31:0]           data_wdata_o,
    input  logic                  data_rvalid_i,
    input  logic [31:0]           data_rdata_i
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GNT1  = 3'd1,
        RVAL1 = 3'd2,
        GNT2  = 3'd3,
        RVAL2 = 3'd4
    } state_e;

    function automatic logic [31:0] rotr32(input logic [31:0] d, input logic [1:0] o);
        logic [63:0] dd;
        dd = {d, d} >> {o, 3'b000};
        return dd[31:0];
    endfunction

    function automatic logic [31:0] rotl32(input logic [31:0] d, input logic [1:0] o);
        logic [63:0] dd;
        dd = {d, d} << {o, 3'b000};
        return dd[63:32];
    endfunction

    state_e                 state_r, state_s;
    logic                   we_r;
    logic [1:0]             type_r;
    logic [1:0]             ext_r;
    logic [ADDR_WIDTH-1:0]  addr_r;
    logic [31:0]            wdata_r;
    logic [31:0]            hold_r;
    logic                   split_r;

    logic                   accept_s;
    logic                   split_in_s;
    logic                   finish_s;
    logic                   req_phase_s;
    logic [1:0]             off_s;
    logic [3:0]             be_first_s;
    logic [3:0]             be_second_s;
    logic [31:0]            rot_new_s;
    logic [31:0]            rot_hold_s;
    logic [31:0]            merged_s;
    logic [31:0]            ext_data_s;
    logic [ADDR_WIDTH-1:0]  aligned_s;

    assign off_s       = addr_r[1:0];
    assign accept_s    = lsu_req_i & (state_r == IDLE);
    assign split_in_s  = ((lsu_type_i == 2'b00) & (lsu_addr_i[1:0] != 2'b00)) |
                         ((lsu_type_i == 2'b01) & (lsu_addr_i[1:0] == 2'b11));
    assign req_phase_s = (state_r == GNT1) | (state_r == GNT2);
    assign finish_s    = data_rvalid_i &
                         (((state_r == RVAL1) & ~split_r) | (state_r == RVAL2));
    assign aligned_s   = {addr_r[ADDR_WIDTH-1:2], 2'b00};

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Request attributes captured at accept; hold word captured after the first split response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_r    <= 1'b0;
            type_r  <= 2'b00;
            ext_r   <= 2'b00;
            addr_r  <= '0;
            wdata_r <= 32'h0000_0000;
            split_r <= 1'b0;
            hold_r  <= 32'h0000_0000;
        end else begin
            if (accept_s) begin
                we_r    <= lsu_we_i;
                type_r  <= lsu_type_i;
                ext_r   <= lsu_ext_i;
                addr_r  <= lsu_addr_i;
                wdata_r <= lsu_wdata_i;
                split_r <= split_in_s;
            end
            if ((state_r == RVAL1) && data_rvalid_i && split_r) begin
                hold_r <= data_rdata_i;
            end
        end
    end

    // Next-state logic; responses outside the RVAL states are ignored.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (lsu_req_i) state_s = GNT1;
                else           state_s = IDLE;
            end
            GNT1: begin
                if (data_gnt_i) state_s = RVAL1;
                else            state_s = GNT1;
            end
            RVAL1: begin
                if (data_rvalid_i) state_s = split_r ? GNT2 : IDLE;
                else               state_s = RVAL1;
            end
            GNT2: begin
                if (data_gnt_i) state_s = RVAL2;
                else            state_s = GNT2;
            end
            RVAL2: begin
                if (data_rvalid_i) state_s = IDLE;
                else               state_s = RVAL2;
            end
            default: state_s = IDLE;
        endcase
    end

    // Byte enables for the first and second halves of an access.
    always_comb begin
        be_first_s  = 4'b0000;
        be_second_s = 4'b0000;
        case (type_r)
            2'b00: begin
                be_first_s  = 4'b1111 << off_s;
                be_second_s = 4'b1111 >> (3'd4 - {1'b0, off_s});
            end
            2'b01: begin
                if (off_s == 2'b11) begin
                    be_first_s  = 4'b1000;
                    be_second_s = 4'b0001;
                end else begin
                    be_first_s  = 4'b0011 << off_s;
                    be_second_s = 4'b0000;
                end
            end
            default: begin
                be_first_s  = 4'b0001 << off_s;
                be_second_s = 4'b0000;
            end
        endcase
    end

    // Merge the two response words (low bytes from the first) then extend.
    always_comb begin
        rot_new_s  = rotr32(data_rdata_i, off_s);
        rot_hold_s = rotr32(hold_r, off_s);
        merged_s   = rot_new_s;
        for (int i = 0; i < 4; i++) begin
            if (split_r && (i < (4 - int'(off_s)))) begin
                merged_s[8*i +: 8] = rot_hold_s[8*i +: 8];
            end else begin
                merged_s[8*i +: 8] = rot_new_s[8*i +: 8];
            end
        end
        case (type_r)
            2'b00:   ext_data_s = merged_s;
            2'b01:   ext_data_s = {{16{ext_r[0] & merged_s[15]}}, merged_s[15:0]};
            default: ext_data_s = {{24{ext_r[0] & merged_s[7]}}, merged_s[7:0]};
        endcase
    end

    // Memory-side and EX-side outputs, zero whenever the matching phase is inactive.
    always_comb begin
        lsu_ready_o  = (state_r == IDLE);
        lsu_busy_o   = (state_r != IDLE);
        lsu_rvalid_o = finish_s;
        data_req_o   = req_phase_s;
        data_we_o    = req_phase_s & we_r;
        if (finish_s && !we_r) begin
            lsu_rdata_o = ext_data_s;
        end else begin
            lsu_rdata_o = 32'h0000_0000;
        end
        if (req_phase_s) begin
            data_wdata_o = rotl32(wdata_r, off_s);
        end else begin
            data_wdata_o = 32'h0000_0000;
        end
        if (state_r == GNT1) begin
            data_addr_o = aligned_s;
            data_be_o   = be_first_s;
        end else if (state_r == GNT2) begin
            data_addr_o = aligned_s + {{(ADDR_WIDTH-3){1'b0}}, 3'b100};
            data_be_o   = be_second_s;
        end else begin
            data_addr_o = '0;
            data_be_o   = 4'b0000;
        end
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit controller between the EX stage and the data-memory port.
- Accepts one load/store request at a time, typed by the shared LSU enums: we_e, type_e (WORD/HALF/BYTE1/BYTE2) and extend_e.
- Drives a req/gnt/rvalid memory handshake, generating byte enables and lane-rotated write data.
- Splits misaligned accesses into two word-aligned transactions, then merges, aligns and sign/zero-extends load data.

Parameters:
- ADDR_WIDTH, 32, byte-address width of lsu_addr_i and data_addr_o. Data width is fixed at 32.

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- lsu_req_i  in  1  request valid from EX
- lsu_ready_o  out  1  controller can accept; high only in IDLE
- lsu_we_i  in  1  we_e: LOAD=0, STORE=1
- lsu_type_i  in  2  type_e: 00 word, 01 half, 1x byte
- lsu_ext_i  in  2  extend_e: bit0=1 sign-extend, else zero-extend
- lsu_addr_i  in  ADDR_WIDTH  byte address
- lsu_wdata_i  in  32  store data, LSB-justified
- lsu_rvalid_o  out  1  one-cycle completion pulse for loads and stores
- lsu_rdata_o  out  32  extended load result, valid with lsu_rvalid_o, 0 for stores
- lsu_busy_o  out  1  any state other than IDLE
- data_req_o  out  1  memory request
- data_gnt_i  in  1  memory grant
- data_addr_o  out  ADDR_WIDTH  word-aligned address (bits[1:0]=0)
- data_we_o  out  1  write enable
- data_be_o  out  4  byte enables
- data_wdata_o  out  32  write data
- data_rvalid_i  in  1  response valid (loads and stores)
- data_rdata_i  in  32  read data

Behaviour:
- Reset (async, rst_ni=0):
  - state=IDLE.
  - All outputs 0 except lsu_ready_o=1.
  - Internal registers cleared.
- FSM states: IDLE, GNT1, RVAL1, GNT2, RVAL2.
- Accept: lsu_req_i & lsu_ready_o in cycle T.
  - Register we/type/ext/addr/wdata and offset o=addr[1:0].
  - Compute split = (word & o!=0) | (half & o==3).
  - Go to GNT1. data_req_o is high from T+1.
- GNT1: data_req_o=1, data_addr_o={addr[hi:2],2'b00}.
  - Hold addr/we/be/wdata stable until gnt.
  - On data_gnt_i: drop req next cycle, go to RVAL1.
- RVAL1: data_req_o=0. On data_rvalid_i:
  - If split: capture rdata into hold register, go to GNT2.
  - Else: lsu_rvalid_o=1 in this same cycle (combinational), go to IDLE.
- GNT2: data_addr_o = aligned addr + 4 (wraps modulo 2^ADDR_WIDTH). Same hold rules as GNT1. On gnt go to RVAL2.
- RVAL2: on data_rvalid_i, lsu_rvalid_o=1 in the same cycle, then IDLE.
- Only one outstanding transaction. data_rvalid_i outside RVAL1/RVAL2 is ignored.
- Minimum aligned latency: accept T, gnt T+1, rvalid T+2 with lsu_rvalid_o at T+2. A new accept is possible at T+3.
- Byte enables (all 4-bit, truncated):
  - Byte: 0001<<o.
  - Half, o<3: 0011<<o.
  - Word, o=0: 1111.
  - Split, first transaction: 1111<<o for word; 1000 for half@3.
  - Split, second transaction: 1111>>(4-o) for word; 0001 for half@3.
- Write data: lsu_wdata_i rotated left by 8*o, identical on both transactions. data_we_o=we in both.
- Load data merge:
  - Unsplit: r = data_rdata_i rotated right by 8*o.
  - Split: r byte i = (i < 4-o) ? rotr(hold,8o)[i] : rotr(data_rdata_i,8o)[i].
- Load extension:
  - Byte: r[7:0] extended from bit 7.
  - Half: r[15:0] extended from bit 15.
  - Word: r.
  - Extension is sign when ext bit0=1, else zero.
- lsu_rdata_o = 0 when not (lsu_rvalid_o & load).
- lsu_req_i while busy is not accepted. Inputs may change freely after the accept cycle.
- Reset mid-operation (any state): immediate return to IDLE.
  - data_req_o drops asynchronously.
  - No lsu_rvalid_o is issued for the aborted access.
  - Any late data_rvalid_i is ignored.

Test Plan:
- Aligned LW: lsu_addr_i=0x100, gnt at T+1, rvalid at T+2 with rdata 0xDEADBEEF.
  - Expect: data_addr_o=0x100, be=1111, we=0.
  - Expect at T+2: lsu_rvalid_o=1, lsu_rdata_o=0xDEADBEEF.
  - Expect: lsu_ready_o=1 at T+3.
- LB sign vs LBU at 0x103, memory word 0x80123456.
  - LB (ext=01): be=1000, result 0xFFFFFF80.
  - LBU (ext=00): result 0x00000080.
- Misaligned SW at 0x102, wdata 0xAABBCCDD.
  - First transaction: addr 0x100, be=1100, wdata 0xCCDDAABB.
  - Second transaction: addr 0x104, be=0011, same wdata.
  - lsu_rvalid_o only after the second rvalid.
- Misaligned LH at 0x103, ext=01.
  - First rdata 0x11000000, second 0x000000F2.
  - be 1000 then 0001; result 0xFFFFF211.
- Gnt stall: data_gnt_i low for 3 cycles in GNT1.
  - data_req_o, data_addr_o, data_be_o, data_wdata_o stable throughout.
  - Extra lsu_req_i pulses are not accepted (lsu_ready_o=0).
- Reset in RVAL2 of a split LW at 0x101.
  - Expect: all outputs 0 and lsu_ready_o=1 immediately.
  - A subsequent data_rvalid_i produces no lsu_rvalid_o.
  - Next aligned LW completes normally.
